// File: rtl/race_sequencer.sv
// Sprint stopwatch race sequencer: conditions start/finish inputs, drives the flag
// command for servo_pwm and runs the millisecond race timer.
module race_sequencer #(
    parameter int TICK_DIV     = 25000,
    parameter int COUNTDOWN_MS = 3000,
    parameter int MIN_LAP_MS   = 500,
    parameter int TIMEOUT_MS   = 60000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        finish_in,
    input  logic        abort,
    output logic        comando_banderin,
    output logic [19:0] elapsed_ms,
    output logic [1:0]  state,
    output logic        race_done,
    output logic        timed_out
);
    // state     | meaning
    // IDLE      | flag down, last race time held, waiting for start
    // COUNTDOWN | flag up, counting COUNTDOWN_MS before "go"
    // RACING    | flag down, elapsed_ms counting, finish/timeout armed
    // FINISHED  | flag up, elapsed_ms frozen, waiting for a new start
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COUNTDOWN = 2'd1;
    localparam logic [1:0] S_RACING    = 2'd2;
    localparam logic [1:0] S_FINISHED  = 2'd3;

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(COUNTDOWN_MS + 1);

    logic          start_meta, start_sync, start_prev;
    logic          finish_meta, finish_sync, finish_prev;
    logic [PW-1:0] prescaler;
    logic [CW-1:0] cd_cnt;

    logic          start_edge, finish_edge, tick, running, enter;
    logic [1:0]    state_nxt;
    logic          flag_nxt, tmo_nxt, done_nxt;
    logic [19:0]   elapsed_nxt, elapsed_inc;
    logic [CW-1:0] cd_nxt, cd_inc;

    assign start_edge  = start_sync & ~start_prev;
    assign finish_edge = finish_sync & ~finish_prev;
    assign tick        = (prescaler == PW'(TICK_DIV - 1));
    assign running     = (state == S_COUNTDOWN) || (state == S_RACING);
    assign elapsed_inc = elapsed_ms + 20'd1;
    assign cd_inc      = cd_cnt + CW'(1);

    always_comb begin
        state_nxt   = state;
        flag_nxt    = comando_banderin;
        elapsed_nxt = elapsed_ms;
        tmo_nxt     = timed_out;
        cd_nxt      = cd_cnt;
        enter       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_nxt   = S_COUNTDOWN;
                    flag_nxt    = 1'b1;
                    elapsed_nxt = '0;
                    cd_nxt      = '0;
                    enter       = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    flag_nxt  = 1'b0;
                    tmo_nxt   = 1'b0;
                end else if (tick) begin
                    cd_nxt = cd_inc;
                    if (cd_inc == CW'(COUNTDOWN_MS)) begin
                        state_nxt = S_RACING;
                        flag_nxt  = 1'b0;
                        enter     = 1'b1;
                    end
                end
            end
            S_RACING: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    flag_nxt  = 1'b0;
                    tmo_nxt   = 1'b0;
                end else begin
                    // the tick still counts when a finish edge lands on it
                    if (tick) elapsed_nxt = elapsed_inc;
                    if (finish_edge && (elapsed_ms >= 20'(MIN_LAP_MS))) begin
                        state_nxt = S_FINISHED;
                        flag_nxt  = 1'b1;
                        tmo_nxt   = 1'b0;
                    end else if (tick && (elapsed_inc == 20'(TIMEOUT_MS))) begin
                        state_nxt = S_FINISHED;
                        flag_nxt  = 1'b1;
                        tmo_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    flag_nxt  = 1'b0;
                    tmo_nxt   = 1'b0;
                end else if (start_edge) begin
                    state_nxt   = S_COUNTDOWN;
                    flag_nxt    = 1'b1;
                    elapsed_nxt = '0;
                    cd_nxt      = '0;
                    tmo_nxt     = 1'b0;
                    enter       = 1'b1;
                end
            end
        endcase
        done_nxt = (state_nxt == S_FINISHED) && (state != S_FINISHED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_meta       <= 1'b0;
            start_sync       <= 1'b0;
            start_prev       <= 1'b0;
            finish_meta      <= 1'b0;
            finish_sync      <= 1'b0;
            finish_prev      <= 1'b0;
            prescaler        <= '0;
            cd_cnt           <= '0;
            state            <= S_IDLE;
            comando_banderin <= 1'b0;
            elapsed_ms       <= '0;
            race_done        <= 1'b0;
            timed_out        <= 1'b0;
        end else begin
            start_meta       <= start_btn;
            start_sync       <= start_meta;
            start_prev       <= start_sync;
            finish_meta      <= finish_in;
            finish_sync      <= finish_meta;
            finish_prev      <= finish_sync;
            if (enter || !running || tick) prescaler <= '0;
            else                           prescaler <= prescaler + PW'(1);
            cd_cnt           <= cd_nxt;
            state            <= state_nxt;
            comando_banderin <= flag_nxt;
            elapsed_ms       <= elapsed_nxt;
            race_done        <= done_nxt;
            timed_out        <= tmo_nxt;
        end
    end
endmodule

// File: tb/tb_race_sequencer.sv
// Scenario bench for race_sequencer: expected snapshots are queued when stimulus
// is applied and compared when the DUT reaches the corresponding output.
module tb_race_sequencer;
    logic        clk = 1'b0;
    logic        reset, start_btn, finish_in, abort;
    logic        comando_banderin, race_done, timed_out;
    logic [19:0] elapsed_ms;
    logic [1:0]  state;

    typedef struct packed {
        logic [1:0]  st;
        logic        flag;
        logic        done;
        logic        tmo;
        logic [19:0] el;
    } snap_t;

    snap_t exp_q[$];
    snap_t got, expv;
    int    n_pass = 0;
    int    n_total = 0;

    always #5 clk = ~clk;

    race_sequencer #(.TICK_DIV(4), .COUNTDOWN_MS(3), .MIN_LAP_MS(5), .TIMEOUT_MS(20)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .finish_in(finish_in), .abort(abort),
        .comando_banderin(comando_banderin), .elapsed_ms(elapsed_ms), .state(state),
        .race_done(race_done), .timed_out(timed_out)
    );

    function automatic snap_t mk(input logic [1:0] st, input logic fl, input logic dn,
                                 input logic tm, input logic [19:0] el);
        snap_t s;
        s.st = st; s.flag = fl; s.done = dn; s.tmo = tm; s.el = el;
        return s;
    endfunction

    function automatic snap_t snap();
        return mk(state, comando_banderin, race_done, timed_out, elapsed_ms);
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("state=%0d flag=%b done=%b tmo=%b elapsed=%0d", s.st, s.flag, s.done, s.tmo, s.el);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_change(input int budget);
        logic [1:0] s0;
        s0 = state;
        for (int i = 0; i < budget; i++) begin
            step();
            if (state != s0) return;
        end
    endtask

    task automatic wait_elapsed(input logic [19:0] v, input int budget);
        for (int i = 0; i < budget && elapsed_ms != v; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start_btn = 1'b0; finish_in = 1'b0; abort = 1'b0;
        steps(3);
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 20'd0));
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL reset: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_normal_race();
        int cd;
        start_btn = 1'b1;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0, 20'd0));
        steps(2);
        n_total++;
        if (state !== 2'd0) $display("FAIL start_latency_early: got state=%0d expected 0", state); else n_pass++;
        step();
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL countdown_entry: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        start_btn = 1'b0;
        cd = 1;
        for (int i = 0; i < 40 && state == 2'd1; i++) begin
            step();
            if (state == 2'd1) cd++;
        end
        n_total++;
        if (cd !== 12) $display("FAIL countdown_length: got %0d cycles expected 12", cd); else n_pass++;
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 20'd0));
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL racing_entry: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        wait_elapsed(20'd8, 60);
        finish_in = 1'b1;
        exp_q.push_back(mk(2'd3, 1'b1, 1'b1, 1'b0, 20'd8));
        wait_change(10);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL finish_accept: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        finish_in = 1'b0;
        exp_q.push_back(mk(2'd3, 1'b1, 1'b0, 1'b0, 20'd8));
        step();
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL done_pulse_width: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        exp_q.push_back(mk(2'd3, 1'b1, 1'b0, 1'b0, 20'd8));
        steps(8);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL finished_frozen: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
    endtask

    task automatic test_early_finish();
        start_btn = 1'b1;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0, 20'd0));
        wait_change(10);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL restart_from_finished: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        start_btn = 1'b0;
        wait_change(20);
        wait_elapsed(20'd2, 20);
        finish_in = 1'b1;
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 20'd4));
        wait_elapsed(20'd4, 20);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL early_finish_rejected: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        finish_in = 1'b0;
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 20'd6));
        wait_elapsed(20'd6, 20);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL rejected_not_remembered: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        finish_in = 1'b1;
        exp_q.push_back(mk(2'd3, 1'b1, 1'b1, 1'b0, 20'd6));
        wait_change(10);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL second_finish: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        finish_in = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        logic [19:0] prev_el;
        start_btn = 1'b1;
        wait_change(10);
        start_btn = 1'b0;
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 20'd0));
        wait_change(20);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL timeout_racing_entry: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        prev_el = elapsed_ms;
        exp_q.push_back(mk(2'd3, 1'b1, 1'b1, 1'b1, 20'd20));
        for (int i = 0; i < 100; i++) begin
            step();
            if (state != 2'd2) break;
            prev_el = elapsed_ms;
        end
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL timeout_finish: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        n_total++;
        if (prev_el !== 20'd19) $display("FAIL timeout_exact: got last racing elapsed=%0d expected 19", prev_el); else n_pass++;
        exp_q.push_back(mk(2'd3, 1'b1, 1'b0, 1'b1, 20'd20));
        step();
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL timeout_level: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        start_btn = 1'b1;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0, 20'd0));
        wait_change(10);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL restart_clears_timeout: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        start_btn = 1'b0;
    endtask

    task automatic test_abort();
        wait_change(20);
        wait_elapsed(20'd7, 40);
        abort = 1'b1;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 20'd7));
        step();
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL abort_racing: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        abort = 1'b0;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 20'd7));
        steps(6);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL idle_holds_elapsed: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
    endtask

    task automatic test_abort_vs_finish();
        int done_seen;
        start_btn = 1'b1;
        wait_change(10);
        start_btn = 1'b0;
        wait_change(20);
        wait_elapsed(20'd6, 40);
        finish_in = 1'b1;
        steps(2);
        abort = 1'b1;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 20'd6));
        step();
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL abort_beats_finish: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        abort = 1'b0;
        finish_in = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (race_done === 1'b1 || state !== 2'd0) done_seen++;
        end
        n_total++;
        if (done_seen !== 0) $display("FAIL abort_no_done: got %0d bad cycles expected 0", done_seen); else n_pass++;
    endtask

    task automatic test_reset_mid_countdown();
        start_btn = 1'b1;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0, 20'd0));
        wait_change(10);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL countdown_clears_elapsed: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        start_btn = 1'b0;
        steps(5);
        reset = 1'b1;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 20'd0));
        step();
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL reset_mid_countdown: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        reset = 1'b0;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 20'd0));
        steps(30);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL no_start_after_reset: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        start_btn = 1'b1;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0, 20'd0));
        wait_change(10);
        got = snap(); expv = exp_q.pop_front(); n_total++;
        if (got !== expv) $display("FAIL start_after_reset: got %s expected %s", fmt(got), fmt(expv)); else n_pass++;
        start_btn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal_race();
        test_early_finish();
        test_timeout();
        test_abort();
        test_abort_vs_finish();
        test_reset_mid_countdown();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/race_sequencer.md
# race_sequencer

Race-sequencing controller for the sprint stopwatch. It turns start, finish-sensor and abort inputs into the flag command (`comando_banderin`) for the existing servo PWM block, and runs the millisecond race timer. The flag is held up during the countdown, dropped to signal "go", and raised again when the race ends. It sits between the board-level button/sensor conditioning in the top level and the `servo_pwm` instance.

## Interface
- `TICK_DIV`, default 25000: clock cycles per 1 ms tick at 25 MHz. Must be ≥ 2.
- `COUNTDOWN_MS`, default 3000: flag-up time before "go". Must be ≥ 1.
- `MIN_LAP_MS`, default 500: finish edges before this elapsed value are ignored.
- `TIMEOUT_MS`, default 60000: race auto-ends at this value. Requires MIN_LAP_MS < TIMEOUT_MS < 2^20.

Ports:
- `clk`  in  1  system clock, 25 MHz. Single clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `start_btn`  in  1  start request, active-high, asynchronous to `clk`, debounced upstream.
- `finish_in`  in  1  finish-line sensor, active-high, asynchronous to `clk`.
- `abort`  in  1  synchronous abort, active-high, sampled directly.
- `comando_banderin`  out  1  flag command to `servo_pwm`: 1 = up, 0 = down.
- `elapsed_ms`  out  20  race time in ms.
- `state`  out  2  IDLE=0, COUNTDOWN=1, RACING=2, FINISHED=3.
- `race_done`  out  1  one-cycle pulse on entry to FINISHED.
- `timed_out`  out  1  level; set when FINISHED was reached by timeout.

## Operation
- Input conditioning:
  - `start_btn` and `finish_in` each pass through a 2-FF synchronizer, then a rising-edge detector on the synchronized value.
  - Level-held inputs produce exactly one edge.
- ms tick:
  - A prescaler counts 0..TICK_DIV-1 in COUNTDOWN and RACING only.
  - It is cleared to 0 on every entry into either state.
  - `tick` = (prescaler == TICK_DIV-1).
- IDLE: flag 0, `elapsed_ms` holds its last value. A start edge moves to COUNTDOWN.
- COUNTDOWN:
  - On entry: flag 1, `elapsed_ms` cleared to 0, countdown counter cleared to 0.
  - Each tick increments the countdown counter.
  - On the tick that makes it equal COUNTDOWN_MS: move to RACING and set flag 0.
  - Start and finish edges are ignored.
- RACING:
  - Each tick increments `elapsed_ms`.
  - A finish edge is accepted only if the registered `elapsed_ms` ≥ MIN_LAP_MS; it then moves to FINISHED with `timed_out`=0.
  - A rejected edge is discarded, not remembered.
  - On the tick that makes `elapsed_ms` == TIMEOUT_MS: move to FINISHED with `timed_out`=1.
- FINISHED:
  - Flag 1, `elapsed_ms` frozen.
  - `race_done` is high for the first cycle only.
  - A start edge moves to COUNTDOWN and clears `timed_out`.
- Abort: in COUNTDOWN, RACING or FINISHED, moves to IDLE on the next edge. Effects: flag 0, `elapsed_ms` held, `timed_out` cleared.
- Priority, highest first: `reset`, then `abort`, then finish edge, then timeout, then tick counting.
  - Finish edge and timeout tick in the same cycle: finish wins, `timed_out`=0, `elapsed_ms` takes the incremented value.
- Reset values: `state` IDLE, `comando_banderin` 0, `elapsed_ms` 0, `race_done` 0, `timed_out` 0, synchronizers/prescaler/counters 0.
- Reset mid-operation: all of the above take effect on the next edge with `reset` high, in any state.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Start/finish latency: if the raw input is first sampled high at edge N, the resulting state change (when accepted) is visible after edge N+2.
- Abort latency: sampled at edge N, IDLE is visible after edge N.
- COUNTDOWN lasts exactly COUNTDOWN_MS×TICK_DIV cycles from entry.
- In RACING, the first `elapsed_ms` increment occurs TICK_DIV cycles after entry.
- `comando_banderin` changes on the same edge as `state`.
- `race_done` is asserted in the same cycle that `state` first reads 3.

## Test plan
All scenarios use TICK_DIV=4, COUNTDOWN_MS=3, MIN_LAP_MS=5, TIMEOUT_MS=20.

1. Reset held 3 cycles from arbitrary state -> `state`=0, flag 0, `elapsed_ms`=0, `race_done`=0, `timed_out`=0.
2. Normal race:
   - Start pulse -> `state`=1 and flag 1 at edge N+2, for exactly 12 cycles; then `state`=2 and flag 0.
   - Finish pulse once `elapsed_ms`=8 -> `state`=3, flag 1, a single `race_done` pulse, `elapsed_ms` frozen at 8.
3. Early finish at `elapsed_ms`=2 -> stays RACING. A second finish at `elapsed_ms`=6 -> FINISHED, `elapsed_ms`=6.
4. No finish -> FINISHED exactly when `elapsed_ms`=20, `timed_out`=1. A later start edge -> COUNTDOWN, `timed_out`=0, `elapsed_ms`=0.
5. Abort in RACING at `elapsed_ms`=7 -> IDLE next edge, flag 0, `elapsed_ms` stays 7.
6. Conflicts:
   - Abort coincident with an accepted finish edge -> IDLE, no `race_done`.
   - Reset mid-COUNTDOWN -> reset values next edge, and no race starts without a new start edge.
